stream_accum: RTL

// - Downstream stage of iir4: consumes the filtered y stream and emits one sample per group of
//   cfg_len accepted inputs (integrate-and-dump decimator): sum >>> cfg_shift, then fitted to W bits.
// - Uses the standard stream flag interface (uc_*/cu_* upstream, cd_*/dc_* downstream), so it

---
 rtl/stream_accum_if.sv | 32 +++
 rtl/stream_accum.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stream_accum_if.sv
// Stream flag bundle for stream_accum: upstream (uc_*/cu_*) and downstream
// (cd_*/dc_*) signals of one stage.
// slave  : the accumulator's view (consumes uc_*, dc_*; drives cu_*, cd_*).
// master : the surrounding environment's view.
interface stream_accum_if #(
  parameter int W = 16
);
  logic [W-1:0] uc_d0;
  logic [3:0]   uc_mflags;
  logic [1:0]   cu_sflags;
  logic [W-1:0] cd_d0;
  logic [3:0]   cd_mflags;
  logic [1:0]   dc_sflags;

  modport master (
    output uc_d0,
    output uc_mflags,
    output dc_sflags,
    input  cu_sflags,
    input  cd_d0,
    input  cd_mflags
  );

  modport slave (
    input  uc_d0,
    input  uc_mflags,
    input  dc_sflags,
    output cu_sflags,
    output cd_d0,
    output cd_mflags
  );
endinterface

// File: rtl/stream_accum.sv
// stream_accum: integrate-and-dump decimator. Sums groups of cfg_len accepted
// samples, emits (sum >>> cfg_shift) fitted to W bits through a single-entry
// output register with backpressure.
// Build option: define STREAM_ACCUM_SAT_EN to saturate the result to W bits;
// otherwise the result wraps (low W bits kept).
//
// state    | meaning
// ST_IDLE  | no partial group; next accepted sample starts a group
// ST_ACC   | partial group in progress (acc/cnt valid)
module stream_accum #(
  parameter int W     = 16,
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cfg_len,
  input  logic [3:0] cfg_shift,
  stream_accum_if.slave s
);

  typedef enum logic {ST_IDLE, ST_ACC} state_e;

  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               len_q, len_d;
  logic [3:0]               shift_q, shift_d;
  logic                     grp_f_q, grp_f_d;
  logic                     out_v_q, out_v_d;
  logic                     out_f_q, out_f_d;
  logic                     out_l_q, out_l_d;
  logic [W-1:0]             out_d_q, out_d_d;

  logic                     in_v, in_l, in_f, in_a;
  logic                     dn_bsy, up_bsy, accept, start, close;
  logic [7:0]               eff_len;
  logic signed [ACC_W-1:0]  din_ext, sum, res;
  logic [3:0]               shift_use;
  logic                     f_use, close_len;
  logic [W-1:0]             res_fit;
  logic                     unused_dc_res;

  assign in_v   = s.uc_mflags[0];
  assign in_l   = s.uc_mflags[1];
  assign in_f   = s.uc_mflags[2];
  assign in_a   = s.uc_mflags[3];
  assign dn_bsy = s.dc_sflags[0];
  assign unused_dc_res = s.dc_sflags[1];

  // A stalled pending output blocks input, so the output register never overwrites.
  assign up_bsy = out_v_q & dn_bsy;

  assign s.cu_sflags = {1'b0, up_bsy};
  assign s.cd_d0     = out_d_q;
  assign s.cd_mflags = {1'b0, out_f_q, out_l_q, out_v_q};

  // Datapath: group start detection, running sum, shift and W-bit fit.
  always_comb begin
    accept    = in_v & ~up_bsy & ~in_a;
    eff_len   = (cfg_len == 8'd0) ? 8'd1 : cfg_len;
    din_ext   = {{(ACC_W-W){s.uc_d0[W-1]}}, s.uc_d0};
    // F mid-group throws away the partial sum and restarts on this sample.
    start     = accept & ((state_q == ST_IDLE) | in_f);
    sum       = start ? din_ext : (acc_q + din_ext);
    shift_use = start ? cfg_shift : shift_q;
    f_use     = start ? in_f : grp_f_q;
    close_len = start ? (eff_len == 8'd1)
                      : (({1'b0, cnt_q} + 9'd1) == {1'b0, len_q});
    close     = accept & (close_len | in_l);
    res       = sum >>> shift_use;
`ifdef STREAM_ACCUM_SAT_EN
    if (res > RES_MAX) begin
      res_fit = RES_MAX[W-1:0];
    end else if (res < RES_MIN) begin
      res_fit = RES_MIN[W-1:0];
    end else begin
      res_fit = res[W-1:0];
    end
`else
    res_fit = res[W-1:0];
`endif
  end

  // Next-state: FSM, accumulator/counter and output register.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    grp_f_d = grp_f_q;
    out_v_d = out_v_q;
    out_f_d = out_f_q;
    out_l_d = out_l_q;
    out_d_d = out_d_q;

    if (out_v_q && !dn_bsy) begin
      out_v_d = 1'b0;
      out_f_d = 1'b0;
      out_l_d = 1'b0;
    end

    if (in_a) begin
      // Abort drops the partial group but leaves any pending output alone.
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      grp_f_d = 1'b0;
    end else if (accept) begin
      if (start) begin
        len_d   = eff_len;
        shift_d = cfg_shift;
        grp_f_d = in_f;
      end
      if (close) begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        grp_f_d = 1'b0;
        out_v_d = 1'b1;
        out_f_d = f_use;
        out_l_d = in_l;
        out_d_d = res_fit;
      end else begin
        state_d = ST_ACC;
        acc_d   = sum;
        cnt_d   = start ? 8'd1 : (cnt_q + 8'd1);
      end
    end
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= 8'd1;
      shift_q <= '0;
      grp_f_q <= 1'b0;
      out_v_q <= 1'b0;
      out_f_q <= 1'b0;
      out_l_q <= 1'b0;
      out_d_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      grp_f_q <= grp_f_d;
      out_v_q <= out_v_d;
      out_f_q <= out_f_d;
      out_l_q <= out_l_d;
      out_d_q <= out_d_d;
    end
  end

endmodule
